// File: rtl/mem_arb_pkg.sv
// Shared state encodings and requester ids for the memory port arbiter.
package mem_arb_pkg;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;

    localparam logic REQ_SCALAR = 1'b0;
    localparam logic REQ_VECTOR = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// Two-way priority picker: prio_idx wins when both request, otherwise the lone requester wins.
module mem_arb_pick (
    input  logic [1:0] req,
    input  logic       prio_idx,
    output logic       grant_idx,
    output logic       any
);
    always_comb begin
        any       = |req;
        grant_idx = req[prio_idx] ? prio_idx : ~prio_idx;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the scalar LSU (0) and the vector LSU (1), one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break priority; default is fixed priority to index 0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*AW-1:0]     req_addr,
    input  logic [2*DW-1:0]     req_wdata,
    input  logic [2*DW/8-1:0]   req_wmask,
    input  logic [1:0]          req_write,
    input  logic [1:0]          req_lock,
    output logic [1:0]          resp_valid,
    output logic [DW-1:0]       resp_rdata,
    output logic [AW-1:0]       m_addr,
    output logic [DW-1:0]       m_wdata,
    output logic [DW/8-1:0]     m_wmask,
    output logic                m_write,
    output logic                m_valid,
    input  logic                m_ready,
    input  logic                m_resp_valid,
    input  logic [DW-1:0]       m_resp_rdata,
    output logic                grant_id,
    output logic                busy
);
    localparam int unsigned MW  = DW / 8;
    localparam int unsigned LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);

    logic [1:0]     state_q, state_d;
    logic           owner_q, owner_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           lock_held_q, lock_held_d;
    logic           prio_idx, pick_idx, pick_any;
    logic           complete, lock_now;

    logic [AW-1:0]  own_addr;
    logic [DW-1:0]  own_wdata;
    logic [MW-1:0]  own_wmask;
    logic           own_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_q, rr_ptr_d;
    assign prio_idx = rr_ptr_q;
`else
    assign prio_idx = REQ_SCALAR;
`endif

    mem_arb_pick u_pick (
        .req       (req_valid),
        .prio_idx  (prio_idx),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign own_addr   = owner_q ? req_addr[AW +: AW]   : req_addr[0 +: AW];
    assign own_wdata  = owner_q ? req_wdata[DW +: DW]  : req_wdata[0 +: DW];
    assign own_wmask  = owner_q ? req_wmask[MW +: MW]  : req_wmask[0 +: MW];
    assign own_write  = req_write[owner_q];
    assign busy       = (state_q != IDLE);
    assign grant_id   = busy & owner_q;
    assign resp_rdata = m_resp_rdata;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lock_cnt_d  = lock_cnt_q;
        lock_held_d = lock_held_q;
        m_valid     = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_wmask     = '0;
        m_write     = 1'b0;
        req_ready   = 2'b00;
        resp_valid  = 2'b00;
        complete    = 1'b0;
        lock_now    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                m_valid            = req_valid[owner_q];
                m_addr             = own_addr;
                m_wdata            = own_wdata;
                m_wmask            = own_wmask;
                m_write            = own_write;
                req_ready[owner_q] = m_ready & req_valid[owner_q];
                lock_now           = req_lock[owner_q];
                if (!req_valid[owner_q]) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (m_ready) begin
                    if (own_write) begin
                        complete = 1'b1;
                    end else if (m_resp_valid) begin
                        resp_valid[owner_q] = 1'b1;
                        complete            = 1'b1;
                    end else begin
                        // The requester may move on once accepted, so remember its lock request.
                        state_d     = WAIT_RESP;
                        lock_held_d = req_lock[owner_q];
                    end
                end
            end
            WAIT_RESP: begin
                lock_now = lock_held_q;
                if (m_resp_valid) begin
                    resp_valid[owner_q] = 1'b1;
                    complete            = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (lock_now && (lock_cnt_q < LOCK_LAST)) begin
                state_d    = GRANT;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q != IDLE && state_d == IDLE) rr_ptr_d = ~owner_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= REQ_SCALAR;
            lock_cnt_q  <= '0;
            lock_held_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= REQ_SCALAR;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_held_q <= lock_held_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a scoreboard.
module tb_mem_port_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MW       = DW / 8;
    localparam int LOCK_MAX = 2;
    localparam int NTX      = 60;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic          write;
        logic          lock;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, req_write, req_lock, resp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*MW-1:0] req_wmask;
    logic [DW-1:0]   resp_rdata, m_wdata, m_resp_rdata;
    logic [AW-1:0]   m_addr;
    logic [MW-1:0]   m_wmask;
    logic            m_write, m_valid, m_ready, m_resp_valid, grant_id, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wmask    (req_wmask),
        .req_write    (req_write),
        .req_lock     (req_lock),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_wmask      (m_wmask),
        .m_write      (m_write),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_resp_valid (m_resp_valid),
        .m_resp_rdata (m_resp_rdata),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid    = '0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wmask    = '0;
        req_write    = '0;
        req_lock     = '0;
        m_ready      = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_rdata = '0;
    endtask

    task automatic drive_req(input int i, input txn_t t);
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = t.addr;
        req_wdata[i*DW +: DW] = t.data;
        req_wmask[i*MW +: MW] = t.mask;
        req_write[i]          = t.write;
        req_lock[i]           = t.lock;
    endtask

    function automatic txn_t mk(input logic [AW-1:0] a, input logic w, input logic lk);
        txn_t t;
        t.addr  = a;
        t.data  = a ^ 32'hA5A5_0000;
        t.mask  = 4'hF;
        t.write = w;
        t.lock  = lk;
        return t;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_req(0, mk(32'h10, 1'b1, 1'b1));
        drive_req(1, mk(32'h20, 1'b0, 1'b1));
        m_ready      = 1'b1;
        m_resp_valid = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({busy, grant_id, m_valid, m_write, m_wmask, req_ready, resp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {busy, grant_id, m_valid, m_write, m_wmask, req_ready, resp_valid});
        end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        do_reset();
        step();
        drive_req(0, mk(32'h100, 1'b0, 1'b0));
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_latency: m_valid=%b, want 0 in request cycle", m_valid);
        end
        step();
        m_ready      = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 32'h100 || m_write !== 1'b0 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL load_issue: m_valid=%b m_addr=%h m_write=%b req_ready=%b, want 1 100 0 01",
                     m_valid, m_addr, m_write, req_ready);
        end
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_resp: resp_valid=%b rdata=%h, want 01 deadbeef", resp_valid, resp_rdata);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL load_idle: busy=%b resp_valid=%b, want 0 00", busy, resp_valid);
        end
    endtask

    task automatic test_tie();
        do_reset();
        step();
        drive_req(0, mk(32'h1000, 1'b1, 1'b0));
        drive_req(1, mk(32'h2000, 1'b1, 1'b0));
        m_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (grant_id !== 1'b0 || m_addr !== 32'h1000 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL tie_first: grant=%b addr=%h ready=%b, want 0 1000 01", grant_id, m_addr, req_ready);
        end
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL tie_gap: busy=%b m_valid=%b, want 0 0", busy, m_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_id !== 1'b1 || m_valid !== 1'b1 || m_addr !== 32'h2000) begin
            errors++;
            $display("FAIL tie_second: grant=%b valid=%b addr=%h, want 1 1 2000", grant_id, m_valid, m_addr);
        end
        step();
        clear_inputs();
    endtask

    // beats: vector addresses; lk: lock flag per beat. Scalar is pending from the first beat.
    task automatic test_lock(input string tag, input logic [AW-1:0] base, input int nbeats,
                             input logic [2:0] lk, input int expect_beats);
        do_reset();
        step();
        drive_req(1, mk(base, 1'b1, lk[0]));
        m_ready = 1'b1;
        for (int b = 0; b < expect_beats; b++) begin
            step();
            drive_req(0, mk(32'h500, 1'b1, 1'b0));
            if (b > 0) drive_req(1, mk(base + 32'(4 * b), 1'b1, lk[b]));
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || grant_id !== 1'b1 || m_addr !== base + 32'(4 * b) || req_ready !== 2'b10) begin
                errors++;
                $display("FAIL %s_beat%0d: busy=%b grant=%b addr=%h ready=%b, want 1 1 %h 10",
                         tag, b, busy, grant_id, m_addr, req_ready, base + 32'(4 * b));
            end
        end
        step();
        if (expect_beats < nbeats) drive_req(1, mk(base + 32'(4 * expect_beats), 1'b1, 1'b1));
        else req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: busy=%b, want 0 after beat %0d", tag, busy, expect_beats);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_id !== 1'b0 || m_valid !== 1'b1 || m_addr !== 32'h500) begin
            errors++;
            $display("FAIL %s_scalar_next: grant=%b valid=%b addr=%h, want 0 1 500", tag, grant_id, m_valid, m_addr);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_wait_resp();
        do_reset();
        step();
        drive_req(0, mk(32'h400, 1'b0, 1'b0));
        step();
        m_ready = 1'b1;
        drive_req(1, mk(32'h600, 1'b1, 1'b0));
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 32'h400 || req_ready !== 2'b01 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL wait_accept: valid=%b addr=%h ready=%b resp=%b, want 1 400 01 00",
                     m_valid, m_addr, req_ready, resp_valid);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            req_valid[0] = 1'b0;
            m_resp_valid = (k == 3);
            m_resp_rdata = 32'h1234_5678;
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || m_valid !== 1'b0 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL wait_hold%0d: busy=%b valid=%b ready=%b, want 1 0 00", k, busy, m_valid, req_ready);
            end
            checks++;
            if (resp_valid !== ((k == 3) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL wait_resp%0d: resp_valid=%b, want %b", k, resp_valid, (k == 3) ? 2'b01 : 2'b00);
            end
        end
        step();
        m_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 2'b00) begin
            errors++;
            $display("FAIL wait_done: busy=%b resp=%b, want 0 00", busy, resp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_id !== 1'b1 || m_valid !== 1'b1 || m_addr !== 32'h600) begin
            errors++;
            $display("FAIL wait_other_next: grant=%b valid=%b addr=%h, want 1 1 600", grant_id, m_valid, m_addr);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        drive_req(0, mk(32'h700, 1'b0, 1'b0));
        step();
        m_ready = 1'b1;
        step();
        req_valid = 2'b00;
        m_ready   = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_waiting: busy=%b, want 1", busy);
        end
        step();
        rst_n = 1'b0;
        step();
        rst_n        = 1'b1;
        m_resp_valid = 1'b1;
        m_resp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if ({busy, grant_id, m_valid, m_write, m_wmask, req_ready, resp_valid} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b, want all zero",
                     {busy, grant_id, m_valid, m_write, m_wmask, req_ready, resp_valid});
        end
        step();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int got[$];
        do_reset();
        drive_req(0, mk(32'h800, 1'b1, 1'b0));
        drive_req(1, mk(32'h900, 1'b1, 1'b0));
        m_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            step();
            @(negedge clk);
            if (req_ready != 2'b00) got.push_back(req_ready[1] ? 1 : 0);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: %0d grants in 20 cycles, want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
                int want = k % 2;
`else
                int want = 0;
`endif
                checks++;
                if (got[k] != want) begin
                    errors++;
                    $display("FAIL b2b_grant%0d: got %0d, want %0d", k, got[k], want);
                end
            end
        end
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        txn_t q[2][$];
        int   loads[2], resps[2], gap[2], waited[2];
        logic pres[2];
        logic pend, real_resp, load_acc, was_pend;
        int   pend_cnt, d, i;
        logic pend_owner;
        logic [1:0] exp_resp;
        txn_t t;
        for (int r = 0; r < 2; r++) begin
            loads[r] = 0; resps[r] = 0; waited[r] = 0; pres[r] = 1'b0;
            gap[r] = $urandom % 3;
            for (int n = 0; n < NTX; n++) begin
                t.addr  = $urandom;
                t.data  = $urandom;
                t.mask  = $urandom;
                t.write = $urandom % 2;
                t.lock  = (n != NTX - 1) && ($urandom % 3 == 0);
                if (!t.write) loads[r]++;
                q[r].push_back(t);
            end
        end
        pend = 1'b0; pend_cnt = 0; pend_owner = 1'b0; d = 0;
        do_reset();
        for (int cyc = 0; cyc < 4000 && (q[0].size() + q[1].size() != 0 || pend); cyc++) begin
            step();
            for (int r = 0; r < 2; r++) begin
                if (!pres[r] && q[r].size() != 0) begin
                    if (gap[r] == 0) pres[r] = 1'b1;
                    else gap[r]--;
                end
                if (pres[r]) drive_req(r, q[r][0]);
                else req_valid[r] = 1'b0;
            end
            #1;
            real_resp    = 1'b0;
            load_acc     = 1'b0;
            was_pend     = pend;
            m_resp_rdata = $urandom;
            if (pend) begin
                m_ready      = $urandom % 2;
                pend_cnt--;
                m_resp_valid = (pend_cnt == 0);
                real_resp    = m_resp_valid;
            end else begin
                m_ready  = ($urandom % 3 != 0);
                load_acc = m_valid && m_ready && !m_write;
                d        = $urandom % 4;
                if (load_acc) begin
                    m_resp_valid = (d == 0);
                    real_resp    = (d == 0);
                end else begin
                    m_resp_valid = ($urandom % 6 == 0);
                end
            end
            @(negedge clk);
            exp_resp = 2'b00;
            if (was_pend && real_resp) exp_resp[pend_owner] = 1'b1;
            if (!busy) begin
                checks++;
                if ({m_valid, m_write, m_wmask, req_ready, grant_id} !== '0) begin
                    errors++;
                    $display("FAIL rnd_idle_quiet: cyc %0d got %b, want zero", cyc,
                             {m_valid, m_write, m_wmask, req_ready, grant_id});
                end
            end
            if (was_pend) begin
                checks++;
                if (m_valid !== 1'b0 || req_ready !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_wait_quiet: cyc %0d valid=%b ready=%b, want 0 00", cyc, m_valid, req_ready);
                end
            end
            checks++;
            if ((req_ready != 2'b00) !== (m_valid && m_ready)) begin
                errors++;
                $display("FAIL rnd_ready: cyc %0d ready=%b with valid=%b m_ready=%b", cyc, req_ready, m_valid, m_ready);
            end
            if (req_ready != 2'b00) begin
                i = req_ready[1] ? 1 : 0;
                t = q[i].size() != 0 ? q[i][0] : '0;
                checks++;
                if ((req_ready != 2'b01 && req_ready != 2'b10) || !pres[i] || grant_id !== i[0] ||
                    m_addr !== t.addr || m_wdata !== t.data || m_wmask !== t.mask || m_write !== t.write) begin
                    errors++;
                    $display("FAIL rnd_accept: cyc %0d ready=%b grant=%b addr=%h data=%h mask=%h wr=%b, want req %0d addr=%h data=%h mask=%h wr=%b",
                             cyc, req_ready, grant_id, m_addr, m_wdata, m_wmask, m_write, i, t.addr, t.data, t.mask, t.write);
                end
                if (pres[i] && q[i].size() != 0) begin
                    void'(q[i].pop_front());
                    pres[i] = 1'b0;
                    gap[i]  = t.lock ? 0 : $urandom % 3;
                end
                if (load_acc && real_resp) exp_resp[i] = 1'b1;
                if (load_acc && !real_resp) begin
                    pend = 1'b1; pend_cnt = d; pend_owner = i[0];
                end
                waited[i] = 0;
                if (pres[1 - i]) begin
                    waited[1 - i]++;
`ifdef ARB_ROUND_ROBIN_EN
                    if (1) begin
`else
                    if (i == 1) begin
`endif
                        checks++;
                        if (waited[1 - i] > LOCK_MAX) begin
                            errors++;
                            $display("FAIL rnd_starve: cyc %0d req %0d passed over %0d times, limit %0d",
                                     cyc, 1 - i, waited[1 - i], LOCK_MAX);
                        end
                    end
                end
            end
            if (was_pend && real_resp) pend = 1'b0;
            checks++;
            if (resp_valid !== exp_resp) begin
                errors++;
                $display("FAIL rnd_resp: cyc %0d resp_valid=%b, want %b", cyc, resp_valid, exp_resp);
            end else if (exp_resp != 2'b00) begin
                checks++;
                if (resp_rdata !== m_resp_rdata) begin
                    errors++;
                    $display("FAIL rnd_rdata: cyc %0d rdata=%h, want %h", cyc, resp_rdata, m_resp_rdata);
                end
            end
            for (int r = 0; r < 2; r++) if (resp_valid[r] === 1'b1) resps[r]++;
        end
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (q[r].size() != 0 || resps[r] != loads[r]) begin
                errors++;
                $display("FAIL rnd_drain%0d: %0d left, %0d responses, want 0 left %0d responses",
                         r, q[r].size(), resps[r], loads[r]);
            end
        end
        step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_load();
        test_tie();
        test_lock("lock", 32'h200, 2, 3'b001, 2);
        test_lock("lockmax", 32'h300, 3, 3'b111, LOCK_MAX);
        test_wait_resp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
